// File: rtl/lane_swap_pkg.sv
// Shared constants for the lane swapper: permutation mode encodings and the
// rotate-amount width derivation.
package lane_swap_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_PAIR = 2'd1;
    localparam logic [1:0] MODE_REV  = 2'd2;
    localparam logic [1:0] MODE_ROT  = 2'd3;

    // Rotate field is wide enough to name any lane, but never narrower than 1 bit.
    function automatic int rot_w(input int num_lanes);
        return (num_lanes <= 2) ? 1 : $clog2(num_lanes);
    endfunction

endpackage

// File: rtl/lane_permute.sv
// Combinational lane permutation: each output lane picks its source lane from
// the mode and rotate amount.
module lane_permute
    import lane_swap_pkg::*;
#(
    parameter  int LANE_W    = 4,
    parameter  int NUM_LANES = 2,
    localparam int DATA_W    = LANE_W * NUM_LANES,
    localparam int ROT_W     = rot_w(NUM_LANES)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic [ROT_W-1:0]  rot,
    output logic [DATA_W-1:0] permuted
);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        // With an odd lane count the last lane has no partner and stays put.
        localparam int PAIR_SRC = ((NUM_LANES % 2 == 1) && (gi == NUM_LANES - 1)) ? gi : (gi ^ 1);
        localparam int REV_SRC  = NUM_LANES - 1 - gi;

        int w_src;

        always_comb begin
            w_src = gi;
            unique case (mode)
                MODE_PASS: w_src = gi;
                MODE_PAIR: w_src = PAIR_SRC;
                MODE_REV:  w_src = REV_SRC;
                MODE_ROT:  w_src = (gi + NUM_LANES - (int'(rot) % NUM_LANES)) % NUM_LANES;
                default:   w_src = gi;
            endcase
        end

        assign permuted[gi*LANE_W +: LANE_W] = data[w_src*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/lane_swapper.sv
// Handshaked lane permuter: permute in front of a registered output stage with
// a one-entry skid buffer, plus a saturating delivered-beat counter.
module lane_swapper
    import lane_swap_pkg::*;
#(
    parameter  int LANE_W    = 4,
    parameter  int NUM_LANES = 2,
    parameter  int CNT_W     = 16,
    localparam int DATA_W    = LANE_W * NUM_LANES,
    localparam int ROT_W     = rot_w(NUM_LANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic [ROT_W-1:0]  in_rot,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beat_count
);

    logic [DATA_W-1:0] w_perm;
    logic              w_accept;
    logic              w_deliver;
    logic              w_out_free;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_valid;
    logic [CNT_W-1:0]  r_beat_count;

    lane_permute #(
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) u_permute (
        .data     (in_data),
        .mode     (in_mode),
        .rot      (in_rot),
        .permuted (w_perm)
    );

    // in_ready comes straight from the skid flag, so it never depends on out_ready.
    assign w_accept   = in_valid && !r_skid_valid;
    assign w_deliver  = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_beat_count <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_data  <= w_perm;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // Output is stalled: park the beat until the consumer drains.
                r_skid_data  <= w_perm;
                r_skid_valid <= 1'b1;
            end

            if (w_deliver && (r_beat_count != {CNT_W{1'b1}})) begin
                r_beat_count <= r_beat_count + CNT_W'(1);
            end
        end
    end

    assign in_ready   = !r_skid_valid;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign beat_count = r_beat_count;

endmodule
